qpu_ifu_ifetch: RTL and testbench
=================================

# qpu_ifu_ifetch

Instruction-fetch stage of the QPU pipeline. It generates the PC, issues single-outstanding fetch requests to instruction memory, and holds the returned word in an IR register. The IR register feeds `QPU_exu_decode` with `i_instr`, `i_pc` and `i_prdt_taken`. It applies static backward-taken prediction to classical branches and redirects on a pipeline flush from the EXU.

## Interface
Parameters:
- `PC_SIZE`, default `QPU_PC_SIZE` (32): PC width.
- `INSTR_SIZE`, default `QPU_INSTR_SIZE` (32): instruction width.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `clk` in 1: single clock; all flops on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ifu_req_valid` out 1: fetch request valid.
- `ifu_req_ready` in 1: memory accepts request.
- `ifu_req_pc` out PC_SIZE: fetch address.
- `ifu_rsp_valid` in 1: instruction word returned.
- `ifu_rsp_ready` out 1: IFU can take response.
- `ifu_rsp_instr` in INSTR_SIZE: returned word.
- `ifu_o_valid` out 1: IR holds a valid instruction.
- `ifu_o_ready` in 1: decode/dispatch consumes IR.
- `ifu_o_ir` out INSTR_SIZE: to decode `i_instr`.
- `ifu_o_pc` out PC_SIZE: to decode `i_pc`.
- `ifu_o_prdt_taken` out 1: to decode `i_prdt_taken`.
- `pipe_flush_req` in 1: redirect request from the EXU (mispredict or branch resolve).
- `pipe_flush_pc` in PC_SIZE: redirect target.

## Operation
- FSM states:
  - RST: held while reset is active.
  - REQ: `ifu_req_valid`=1.
  - WAIT: one request outstanding.
- Transitions:
  - RST→REQ: first cycle after `rst_n` rises.
  - REQ→WAIT: on `ifu_req_valid & ifu_req_ready`.
  - WAIT→REQ: on response handshake `ifu_rsp_valid & ifu_rsp_ready`.
- `ifu_rsp_ready` = `~ir_valid | ifu_o_ready | discard`.
- On response handshake with `discard`=0:
  - IR, `ifu_o_pc` and `ifu_o_prdt_taken` load.
  - `ir_valid` is set.
  - `pc_nxt` is computed from the word.
- Branch detection: the word is a branch when bit0=0 and bits[4:0]=`5'b11000`.
- Branch immediate: `b_imm` = sign-extend({instr[9:5], instr[23:15]}), 14 bits.
- Branch target: `pc + (b_imm << 2)`, modulo 2^PC_SIZE. Immediate bit 0 corresponds to address bit 2.
- Prediction: taken if and only if the word is a branch and instr[9]=1 (backward branch).
- Next PC: taken ⇒ `pc_nxt` = target; otherwise `pc_nxt` = `pc + 4`, wrapping at 2^PC_SIZE.
- Quantum words (bit0=1) are never predicted; next PC is always `pc + 4`.
- IR consume: `ifu_o_valid & ifu_o_ready` clears `ir_valid` unless a new response loads in the same cycle.
- `ifu_req_pc` is stable while `ifu_req_valid`=1 and not accepted. The only exception is a flush.
- Flush has priority over every other event in the cycle:
  - `ir_valid` clears.
  - The fetch PC becomes `pipe_flush_pc`.
  - The FSM goes to REQ.
  - If a request is outstanding (WAIT, or REQ accepted in the flush cycle), `discard` is set.
- A response arriving while `discard`=1:
  - It is accepted (`ifu_rsp_ready`=1) and dropped.
  - `discard` clears.
  - In that case the FSM holds in REQ and does not issue until `discard`=0.
- A response in the same cycle as a flush is accepted and dropped. `discard` is not set for it.

## Timing
- Reset values of all outputs:
  - `ifu_req_valid`=0, `ifu_rsp_ready`=0, `ifu_o_valid`=0, `ifu_o_prdt_taken`=0.
  - `ifu_o_ir`=0, `ifu_o_pc`=0.
  - `ifu_req_pc`=RESET_PC.
- Reset mid-operation: the IFU returns to RST immediately.
- First cycle after reset release: `ifu_req_valid`=1 with `ifu_req_pc`=RESET_PC.
- Response handshake in cycle N ⇒ `ifu_o_valid`=1 in N+1, and the next request is driven in N+1.
- Peak throughput: one instruction per 2 cycles with zero-wait memory.
- Flush in cycle N ⇒ `ifu_o_valid`=0 and `ifu_req_pc`=`pipe_flush_pc` in N+1. The request is driven in N+1 unless `discard` is pending.
- Backpressure: while `ir_valid`=1 and `ifu_o_ready`=0, `ifu_rsp_ready`=0.

## Structure
- Shared package additions in `QPU_defines.v`:
  - `QPU_BRANCH_OPCODE` (5'b11000).
  - `QPU_PC_INC` (4).
  - The FSM state encodings (2 bits).
- Sub-module `qpu_ifu_minidec`, purely combinational:
  - Input: instruction word and PC.
  - Outputs: `is_bxx`, `prdt_taken` and `pc_nxt`.
- All state (FSM, `pc`, `discard`, IR pipe registers) stays in the top module.

## Test plan
- **Reset and sequential fetch:** release reset with `RESET_PC`=0, memory has zero wait, words are non-branch. Expect:
  - requests to 0x0, 0x4, 0x8;
  - IR PCs 0x0, 0x4, 0x8 on alternate cycles;
  - `ifu_o_prdt_taken`=0.
- **Backward branch at 0x40:** word has bits[4:0]=11000, instr[9]=1, imm=-4. Expect `ifu_o_prdt_taken`=1 and next request 0x30.
- **Forward branch:** instr[9]=0. Expect `prdt_taken`=0 and next request 0x44.
- **Backpressure:** hold `ifu_o_ready`=0 for 5 cycles with a response pending. Expect:
  - `ifu_rsp_ready`=0 throughout;
  - IR stable;
  - on release the next word loads one cycle after consume.
- **Flush in WAIT:** flush to 0x100 while a request to 0x8 is outstanding, and the stale response arrives 2 cycles later. Expect:
  - the stale word is dropped, `ifu_o_valid` stays 0;
  - the next request is 0x100;
  - IR later shows PC 0x100.
- **Flush racing a response:** flush in the same cycle as a response. Expect:
  - the word is dropped, `discard` stays 0;
  - request 0x100 is issued the next cycle.
- **Asynchronous reset mid-WAIT:** assert `rst_n`=0 while in WAIT. Expect all outputs at reset values immediately.

Source files
------------

// File: rtl/qpu_ifu_ifetch_pkg.sv
// ============================================================================
// Module   : qpu_ifu_ifetch_pkg
// Purpose  : Shared constants and FSM state encoding for the QPU instruction
//            fetch unit.
// Contents : QPU_PC_SIZE, QPU_INSTR_SIZE, QPU_BRANCH_OPCODE, QPU_PC_INC,
//            ifu_state_e (2-bit fetch FSM states)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package qpu_ifu_ifetch_pkg;

    localparam int QPU_PC_SIZE    = 32;
    localparam int QPU_INSTR_SIZE = 32;

    // Low five bits of a classical conditional branch (bit 0 = 0 marks a
    // classical word, bit 0 = 1 a quantum word).
    localparam logic [4:0] QPU_BRANCH_OPCODE = 5'b11000;

    // Sequential fetch stride in bytes.
    localparam int QPU_PC_INC = 4;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } ifu_state_e;

endpackage : qpu_ifu_ifetch_pkg

`default_nettype wire

// File: rtl/qpu_ifu_minidec.sv
// ============================================================================
// Module   : qpu_ifu_minidec
// Purpose  : Combinational pre-decoder for the fetch stage. Detects classical
//            branches, applies static backward-taken prediction and computes
//            the next fetch address.
// Ports    : instr      in  INSTR_SIZE  fetched instruction word
//            pc         in  PC_SIZE     address the word was fetched from
//            is_bxx     out 1           word is a classical branch
//            prdt_taken out 1           branch predicted taken (backward)
//            pc_nxt     out PC_SIZE     predicted next fetch address
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qpu_ifu_minidec
    import qpu_ifu_ifetch_pkg::*;
#(
    parameter int PC_SIZE    = QPU_PC_SIZE,
    parameter int INSTR_SIZE = QPU_INSTR_SIZE
) (
    input  logic [INSTR_SIZE-1:0] instr,
    input  logic [PC_SIZE-1:0]    pc,
    output logic                  is_bxx,
    output logic                  prdt_taken,
    output logic [PC_SIZE-1:0]    pc_nxt
);

    localparam int IMM_W = 14;

    logic [IMM_W-1:0]   w_b_imm;
    logic [PC_SIZE-1:0] w_imm_ext;
    logic [PC_SIZE-1:0] w_target;
    logic               w_unused;

    // Immediate sign bit is instr[9], so "taken" and "backward" are the same
    // test: the prediction needs no adder on the immediate.
    assign w_b_imm   = {instr[9:5], instr[23:15]};
    assign w_imm_ext = {{(PC_SIZE-IMM_W){w_b_imm[IMM_W-1]}}, w_b_imm};

    // Immediate counts words; shift by two to reach byte addresses.
    assign w_target  = pc + (w_imm_ext << 2);

    // Quantum words carry bit 0 = 1 and can never match the opcode, but the
    // classical check is kept explicit for readability.
    assign is_bxx     = ~instr[0] & (instr[4:0] == QPU_BRANCH_OPCODE);
    assign prdt_taken = is_bxx & instr[9];
    assign pc_nxt     = prdt_taken ? w_target : (pc + PC_SIZE'(QPU_PC_INC));

    assign w_unused = ^{instr[INSTR_SIZE-1:24], instr[14:10]};

endmodule : qpu_ifu_minidec

`default_nettype wire

// File: rtl/qpu_ifu_ifetch.sv
// ============================================================================
// Module   : qpu_ifu_ifetch
// Purpose  : QPU instruction-fetch stage. Generates the PC, issues single-
//            outstanding fetch requests, holds the returned word in the IR,
//            predicts classical branches statically and redirects on flush.
// Ports    : clk, rst_n                     clock / async active-low reset
//            ifu_req_valid/ready/pc         fetch request channel
//            ifu_rsp_valid/ready/instr      fetch response channel
//            ifu_o_valid/ready              IR handshake towards decode
//            ifu_o_ir/pc/prdt_taken         IR contents towards decode
//            pipe_flush_req/pc              redirect from the EXU
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qpu_ifu_ifetch
    import qpu_ifu_ifetch_pkg::*;
#(
    parameter int                 PC_SIZE    = QPU_PC_SIZE,
    parameter int                 INSTR_SIZE = QPU_INSTR_SIZE,
    parameter logic [PC_SIZE-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    output logic [PC_SIZE-1:0]    ifu_req_pc,

    input  logic                  ifu_rsp_valid,
    output logic                  ifu_rsp_ready,
    input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,

    output logic                  ifu_o_valid,
    input  logic                  ifu_o_ready,
    output logic [INSTR_SIZE-1:0] ifu_o_ir,
    output logic [PC_SIZE-1:0]    ifu_o_pc,
    output logic                  ifu_o_prdt_taken,

    input  logic                  pipe_flush_req,
    input  logic [PC_SIZE-1:0]    pipe_flush_pc
);

    ifu_state_e             r_state;
    ifu_state_e             w_state_nxt;

    logic [PC_SIZE-1:0]     r_pc;
    logic                   r_discard;
    logic                   r_ir_valid;
    logic [INSTR_SIZE-1:0]  r_ir;
    logic [PC_SIZE-1:0]     r_ir_pc;
    logic                   r_ir_taken;

    logic                   w_req_hs;
    logic                   w_rsp_hs;
    logic                   w_load;
    logic                   w_consume;
    logic                   w_outstanding;
    logic                   w_is_bxx;
    logic                   w_prdt_taken;
    logic [PC_SIZE-1:0]     w_pc_nxt;
    logic                   w_unused;

    qpu_ifu_minidec #(
        .PC_SIZE    (PC_SIZE),
        .INSTR_SIZE (INSTR_SIZE)
    ) u_minidec (
        .instr      (ifu_rsp_instr),
        .pc         (r_pc),
        .is_bxx     (w_is_bxx),
        .prdt_taken (w_prdt_taken),
        .pc_nxt     (w_pc_nxt)
    );

    assign w_unused = w_is_bxx;

    assign w_req_hs  = ifu_req_valid & ifu_req_ready;
    assign w_rsp_hs  = ifu_rsp_valid & ifu_rsp_ready;
    // A response is only kept if it is neither stale nor raced by a flush.
    assign w_load    = w_rsp_hs & ~r_discard & ~pipe_flush_req;
    assign w_consume = r_ir_valid & ifu_o_ready;

    // A request will still be in flight after this edge: either the one
    // already outstanding (WAIT, or a stale one) that is not returning now,
    // or one being accepted right now.
    assign w_outstanding = (((r_state == ST_WAIT) | r_discard) & ~w_rsp_hs) | w_req_hs;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        ifu_req_valid = 1'b0;
        ifu_rsp_ready = 1'b0;

        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                // Hold off issuing until the stale response has drained.
                ifu_req_valid = ~r_discard;
                ifu_rsp_ready = ~r_ir_valid | ifu_o_ready | r_discard;
                if (w_req_hs) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                ifu_rsp_ready = ~r_ir_valid | ifu_o_ready | r_discard;
                if (w_rsp_hs) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase

        if (pipe_flush_req) begin
            w_state_nxt = ST_REQ;
        end
    end

    // ------------------------------------------------------------------
    // PC, discard flag and IR pipe registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_discard  <= 1'b0;
            r_ir_valid <= 1'b0;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_taken <= 1'b0;
        end else begin
            if (pipe_flush_req) begin
                r_pc       <= pipe_flush_pc;
                r_discard  <= w_outstanding;
                r_ir_valid <= 1'b0;
            end else begin
                if (w_rsp_hs) begin
                    r_discard <= 1'b0;
                end
                if (w_load) begin
                    r_pc       <= w_pc_nxt;
                    r_ir_valid <= 1'b1;
                end else if (w_consume) begin
                    r_ir_valid <= 1'b0;
                end
            end

            if (w_load) begin
                r_ir       <= ifu_rsp_instr;
                r_ir_pc    <= r_pc;
                r_ir_taken <= w_prdt_taken;
            end
        end
    end

    assign ifu_req_pc       = r_pc;
    assign ifu_o_valid      = r_ir_valid;
    assign ifu_o_ir         = r_ir;
    assign ifu_o_pc         = r_ir_pc;
    assign ifu_o_prdt_taken = r_ir_taken;

endmodule : qpu_ifu_ifetch

`default_nettype wire

// File: tb/tb_qpu_ifu_ifetch.sv
// ============================================================================
// Module   : tb_qpu_ifu_ifetch
// Purpose  : Self-checking bench for qpu_ifu_ifetch. A random-latency memory
//            and a random consumer/flush source drive the DUT; a transaction
//            level model of the fetch stream predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qpu_ifu_ifetch;

    localparam int          PW  = 32;
    localparam int          IW  = 32;
    localparam logic [31:0] RPC = 32'h0;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ifu_req_valid;
    logic           ifu_req_ready = 1'b0;
    logic [PW-1:0]  ifu_req_pc;
    logic           ifu_rsp_valid = 1'b0;
    logic           ifu_rsp_ready;
    logic [IW-1:0]  ifu_rsp_instr = '0;
    logic           ifu_o_valid;
    logic           ifu_o_ready = 1'b0;
    logic [IW-1:0]  ifu_o_ir;
    logic [PW-1:0]  ifu_o_pc;
    logic           ifu_o_prdt_taken;
    logic           pipe_flush_req = 1'b0;
    logic [PW-1:0]  pipe_flush_pc = '0;

    qpu_ifu_ifetch #(
        .PC_SIZE    (PW),
        .INSTR_SIZE (IW),
        .RESET_PC   (RPC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ifu_req_valid    (ifu_req_valid),
        .ifu_req_ready    (ifu_req_ready),
        .ifu_req_pc       (ifu_req_pc),
        .ifu_rsp_valid    (ifu_rsp_valid),
        .ifu_rsp_ready    (ifu_rsp_ready),
        .ifu_rsp_instr    (ifu_rsp_instr),
        .ifu_o_valid      (ifu_o_valid),
        .ifu_o_ready      (ifu_o_ready),
        .ifu_o_ir         (ifu_o_ir),
        .ifu_o_pc         (ifu_o_pc),
        .ifu_o_prdt_taken (ifu_o_prdt_taken),
        .pipe_flush_req   (pipe_flush_req),
        .pipe_flush_pc    (pipe_flush_pc)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Program memory (indexed by pc[9:2]) and fetch-stream rules
    // ------------------------------------------------------------------
    logic [31:0] mem [256];

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return mem[pc[9:2]];
    endfunction

    function automatic bit is_taken(input logic [31:0] w);
        return (w[4:0] == 5'b11000) && w[9];
    endfunction

    // Taken branches always have a negative 14-bit word offset.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w);
        int raw;
        if (is_taken(w)) begin
            raw = int'({w[9:5], w[23:15]});
            return pc - 32'((16384 - raw) * 4);
        end
        return pc + 32'd4;
    endfunction

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    bit          m_irv;
    logic [31:0] m_ir, m_irpc;
    bit          m_irt;
    logic [31:0] m_fpc;     // address the next/current request must carry
    bit          m_pend;    // memory holds a request
    bit          m_stale;   // that request's answer must be thrown away
    logic [31:0] m_ppc;
    int          m_dly;
    bit          m_rspv;

    task automatic model_reset();
        m_irv = 0; m_ir = '0; m_irpc = '0; m_irt = 0;
        m_fpc = RPC; m_pend = 0; m_stale = 0; m_ppc = '0; m_dly = 0; m_rspv = 0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_req_valid"}, 64'(ifu_req_valid), 64'd0);
        chk({pfx, "_rsp_ready"}, 64'(ifu_rsp_ready), 64'd0);
        chk({pfx, "_o_valid"},   64'(ifu_o_valid), 64'd0);
        chk({pfx, "_o_taken"},   64'(ifu_o_prdt_taken), 64'd0);
        chk({pfx, "_o_ir"},      64'(ifu_o_ir), 64'd0);
        chk({pfx, "_o_pc"},      64'(ifu_o_pc), 64'd0);
        chk({pfx, "_req_pc"},    64'(ifu_req_pc), 64'(RPC));
    endtask

    task automatic drive_idle();
        ifu_req_ready  = 1'b0;
        ifu_rsp_valid  = 1'b0;
        ifu_o_ready    = 1'b0;
        pipe_flush_req = 1'b0;
    endtask

    // Hold reset, check reset values, release on a falling edge.
    task automatic do_reset(input string pfx);
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs(pfx);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // One randomized cycle per iteration: drive, check, advance model.
    // ------------------------------------------------------------------
    task automatic run(input int cycles, input int flush_pct, input int ordy_pct,
                       input int qrdy_pct, input int maxdly);
        bit req_hs, rsp_hs, cons;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            ifu_o_ready    = ($urandom_range(0, 99) < ordy_pct);
            ifu_req_ready  = ($urandom_range(0, 99) < qrdy_pct);
            pipe_flush_req = ($urandom_range(0, 99) < flush_pct);
            pipe_flush_pc  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            m_rspv         = m_pend && (m_dly == 0);
            ifu_rsp_valid  = m_rspv;
            ifu_rsp_instr  = m_rspv ? word_at(m_ppc) : $urandom;
            #1;

            chk("o_valid", 64'(ifu_o_valid), 64'(m_irv));
            if (m_irv) begin
                chk("o_ir",    64'(ifu_o_ir), 64'(m_ir));
                chk("o_pc",    64'(ifu_o_pc), 64'(m_irpc));
                chk("o_taken", 64'(ifu_o_prdt_taken), 64'(m_irt));
            end
            chk("req_valid", 64'(ifu_req_valid), 64'(!m_pend));
            if (!m_pend)
                chk("req_pc", 64'(ifu_req_pc), 64'(m_fpc));
            if (m_rspv)
                chk("rsp_ready", 64'(ifu_rsp_ready), 64'(!m_irv || ifu_o_ready || m_stale));

            req_hs = ifu_req_valid && ifu_req_ready;
            rsp_hs = m_rspv && ifu_rsp_ready;
            cons   = ifu_o_valid && ifu_o_ready;

            if (m_pend && !rsp_hs && m_dly > 0)
                m_dly--;

            if (pipe_flush_req) begin
                if (rsp_hs) begin
                    m_pend = 0; m_stale = 0;
                end else if (m_pend) begin
                    m_stale = 1;
                end
                m_irv = 0;
                if (req_hs) begin
                    m_pend = 1; m_stale = 1; m_ppc = m_fpc;
                    m_dly = $urandom_range(0, maxdly);
                end
                m_fpc = pipe_flush_pc;
            end else begin
                if (rsp_hs && !m_stale) begin
                    m_ir   = word_at(m_ppc);
                    m_irpc = m_ppc;
                    m_irt  = is_taken(m_ir);
                    m_irv  = 1;
                    m_fpc  = ref_next(m_ppc, m_ir);
                end else if (cons) begin
                    m_irv = 0;
                end
                if (rsp_hs) begin
                    m_pend = 0; m_stale = 0;
                end
                if (req_hs) begin
                    m_pend = 1; m_stale = 0; m_ppc = m_fpc;
                    m_dly = $urandom_range(0, maxdly);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Memory image: straight-line code at 0x00..0x2C, a forward branch at
    // 0x30, a backward branch (-4 words) at 0x40, random mix elsewhere.
    // ------------------------------------------------------------------
    task automatic init_mem();
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            case ($urandom_range(0, 3))
                0: w[4:0] = 5'b00010;                           // plain classical
                1: w[0]   = 1'b1;                               // quantum
                2: begin w[4:0] = 5'b11000; w[9:5] = 5'b11111; end // backward
                default: begin w[4:0] = 5'b11000; w[9] = 1'b0; end // forward
            endcase
            mem[i] = w;
        end
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            w[4:0] = 5'b00010;
            mem[i] = w;
        end
        w = 32'h0; w[4:0] = 5'b11000; w[9:5] = 5'b00000; w[23:15] = 9'd2;
        mem[12] = w;                                            // 0x30: fwd +2
        w = 32'h0; w[4:0] = 5'b11000; w[9:5] = 5'b11111; w[23:15] = 9'h1FC;
        mem[16] = w;                                            // 0x40: -4 -> 0x30
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        init_mem();
        model_reset();
        do_reset("rst");

        // Zero-wait memory, always-ready consumer: sequential then looping.
        run(40, 0, 100, 100, 0);
        // Heavy backpressure, slow memory, no flushes.
        run(300, 0, 20, 60, 3);
        // Full random mix including flushes.
        run(3000, 8, 70, 75, 3);

        // Reach a state with a live outstanding request, then reset mid-cycle.
        guard = 0;
        pipe_flush_req = 1'b0;
        while (!(m_pend && !m_stale) && guard < 100) begin
            run(1, 0, 50, 100, 3);
            guard++;
        end
        chk("wait_reached", 64'(m_pend && !m_stale), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        do_reset("rst2");

        run(1500, 8, 70, 75, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_qpu_ifu_ifetch

`default_nettype wire
